// File: rtl/vga_pkg.sv
// Shared screen geometry, pixel record and sink state encoding for the VGA plot path.
package vga_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int FB_ADDR_W = 15;
  localparam logic [FB_ADDR_W-1:0] N_PIX = FB_ADDR_W'(SCREEN_W * SCREEN_H);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } sink_state_t;

  // The 160-wide case uses shift-add so no multiplier is needed.
  function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    logic [FB_ADDR_W-1:0] xe;
    logic [FB_ADDR_W-1:0] ye;
    xe = {7'b0, x};
    ye = {8'b0, y};
    if (SCREEN_W == 160)
      return (ye << 7) + (ye << 5) + xe;
    else
      return (ye * FB_ADDR_W'(SCREEN_W)) + xe;
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO of pixel records; head shows the oldest entry while non-empty.
module plot_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  pixel_t din,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output pixel_t head
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  pixel_t      mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/plot_sink.sv
// Pixel-stream sink: queues plots, clips to the screen, writes the framebuffer, and runs clears.
// state | meaning
// IDLE  | accept plots, drain FIFO, watch clear_start
// FLUSH | plots blocked, drain remaining FIFO entries and the pending write
// CLEAR | write captured colour to every address 0..N_PIX-1
// DONE  | clear_done pulse, back to IDLE
module plot_sink
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           vga_x,
  input  logic [6:0]           vga_y,
  input  logic [2:0]           vga_colour,
  input  logic                 vga_plot,
  output logic                 plot_ready,
  input  logic                 clear_start,
  input  logic [2:0]           clear_colour,
  output logic                 clear_done,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [2:0]           fb_wdata,
  output logic                 fb_we,
  output logic                 busy,
  output logic [15:0]          clip_count
);

  sink_state_t          state;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 accept;
  logic                 clipped;
  pixel_t               in_px;
  pixel_t               head;
  logic [2:0]           clr_colour;
  logic [FB_ADDR_W-1:0] clr_cnt;

  assign plot_ready = !fifo_full && (state == IDLE);
  assign accept     = vga_plot && plot_ready;
  assign clipped    = (32'(vga_x) >= SCREEN_W) || (32'(vga_y) >= SCREEN_H);
  assign fifo_push  = accept && !clipped;
  assign fifo_pop   = !fifo_empty;
  assign in_px      = {vga_x, vga_y, vga_colour};

  plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (in_px),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      clr_colour <= '0;
      clr_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_start) begin
            clr_colour <= clear_colour;
            state      <= FLUSH;
          end
        end
        FLUSH: begin
          if (fifo_empty && !fb_we) begin
            clr_cnt <= '0;
            state   <= CLEAR;
          end
        end
        // Leave once every address has been issued; the last write is visible on this cycle.
        CLEAR: begin
          if (clr_cnt == N_PIX) state <= DONE;
          else                  clr_cnt <= clr_cnt + 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_wdata <= '0;
    end else if (fifo_pop) begin
      fb_we    <= 1'b1;
      fb_addr  <= pix_addr(head.x, head.y);
      fb_wdata <= head.colour;
    end else if ((state == CLEAR) && (clr_cnt != N_PIX)) begin
      fb_we    <= 1'b1;
      fb_addr  <= clr_cnt;
      fb_wdata <= clr_colour;
    end else begin
      fb_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      clip_count <= '0;
    else if (accept && clipped && (clip_count != 16'hFFFF))
      clip_count <= clip_count + 1'b1;
  end

  assign clear_done = (state == DONE);
  assign busy       = !fifo_empty || fb_we || (state != IDLE);

endmodule

// File: tb/tb_plot_sink.sv
// Directed-plus-random bench for plot_sink against a queue-based model of framebuffer writes.
module tb_plot_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        plot_ready;
  logic        clear_start;
  logic [2:0]  clear_colour;
  logic        clear_done;
  logic [14:0] fb_addr;
  logic [2:0]  fb_wdata;
  logic        fb_we;
  logic        busy;
  logic [15:0] clip_count;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  int  n_assert = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  model_clips = 0;
  wr_t got[$];
  int  exp_addr[$];
  int  exp_data[$];

  plot_sink dut (
    .clk          (clk),
    .rst          (rst),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_plot     (vga_plot),
    .plot_ready   (plot_ready),
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .clear_done   (clear_done),
    .fb_addr      (fb_addr),
    .fb_wdata     (fb_wdata),
    .fb_we        (fb_we),
    .busy         (busy),
    .clip_count   (clip_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst === 1'b0 && fb_we === 1'b1)
      got.push_back('{int'(fb_addr), int'(fb_wdata), cyc});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_plot(input int x, input int y, input int c, input logic p);
    vga_x      = 8'(x);
    vga_y      = 7'(y);
    vga_colour = 3'(c);
    vga_plot   = p;
  endtask

  // Reference: screen is 160x120 row-major; anything off-screen is dropped and counted.
  task automatic model_plot(input int x, input int y, input int c);
    if (x >= 160 || y >= 120) begin
      if (model_clips < 65535) model_clips++;
    end else begin
      exp_addr.push_back(y * 160 + x);
      exp_data.push_back(c);
    end
  endtask

  task automatic check_writes(input string tag);
    int errs = 0;
    check({tag, "_count"}, 64'(got.size()), 64'(exp_addr.size()));
    for (int i = 0; i < got.size() && i < exp_addr.size(); i++)
      if (got[i].addr != exp_addr[i] || got[i].data != exp_data[i]) errs++;
    check({tag, "_order"}, 64'(errs), 64'd0);
    got.delete();
    exp_addr.delete();
    exp_data.delete();
  endtask

  initial begin
    int c_start;
    int drops;
    int gaps;
    int k;
    int done_cyc;
    bit done_seen;
    int ready_errs;
    int x;
    int y;
    int c;

    rst = 1'b1;
    clear_start = 1'b0;
    clear_colour = 3'd0;
    set_plot(0, 0, 0, 1'b0);
    repeat (3) tick();
    check("rst_ready", 64'(plot_ready), 64'd1);
    check("rst_we", 64'(fb_we), 64'd0);
    check("rst_addr", 64'(fb_addr), 64'd0);
    check("rst_wdata", 64'(fb_wdata), 64'd0);
    check("rst_done", 64'(clear_done), 64'd0);
    check("rst_clip", 64'(clip_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 64'(plot_ready), 64'd1);

    // single plot, latency N+2
    set_plot(10, 5, 5, 1'b1);
    tick();
    set_plot(0, 0, 0, 1'b0);
    check("lat_n1_we", 64'(fb_we), 64'd0);
    tick();
    check("lat_n2_we", 64'(fb_we), 64'd1);
    check("single_addr", 64'(fb_addr), 64'd810);
    check("single_wdata", 64'(fb_wdata), 64'd5);
    tick();
    check("single_we_off", 64'(fb_we), 64'd0);
    check("single_busy", 64'(busy), 64'd0);
    check("single_hold_addr", 64'(fb_addr), 64'd810);
    got.delete();

    // burst of 20 back-to-back plots
    drops = 0;
    c_start = cyc;
    for (int i = 0; i < 20; i++) begin
      x = int'($urandom_range(0, 159));
      y = int'($urandom_range(0, 119));
      c = int'($urandom_range(0, 7));
      set_plot(x, y, c, 1'b1);
      if (plot_ready !== 1'b1) drops++;
      model_plot(x, y, c);
      tick();
    end
    set_plot(0, 0, 0, 1'b0);
    repeat (4) tick();
    check("burst_ready_drops", 64'(drops), 64'd0);
    gaps = 0;
    for (int i = 1; i < got.size(); i++)
      if (got[i].cyc != got[0].cyc + i) gaps++;
    check("burst_gaps", 64'(gaps), 64'd0);
    if (got.size() > 0) check("burst_first_lat", 64'(got[0].cyc), 64'(c_start + 2));
    check_writes("burst");

    // clipping boundaries
    set_plot(160, 0, 1, 1'b1);
    model_plot(160, 0, 1);
    tick();
    set_plot(0, 120, 2, 1'b1);
    model_plot(0, 120, 2);
    tick();
    set_plot(0, 0, 0, 1'b0);
    repeat (3) tick();
    check("clip_no_write", 64'(got.size()), 64'd0);
    check("clip_count2", 64'(clip_count), 64'd2);
    set_plot(159, 119, 3, 1'b1);
    model_plot(159, 119, 3);
    tick();
    set_plot(0, 0, 0, 1'b0);
    repeat (3) tick();
    check_writes("corner");

    // random coordinates across full input range, random valid
    for (int i = 0; i < 80; i++) begin
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 127));
      c = int'($urandom_range(0, 7));
      set_plot(x, y, c, 1'($urandom_range(0, 3) != 0));
      if (vga_plot && plot_ready === 1'b1) model_plot(x, y, c);
      tick();
    end
    set_plot(0, 0, 0, 1'b0);
    repeat (4) tick();
    check_writes("random");
    check("random_clip_count", 64'(clip_count), 64'(model_clips));

    // clear with 3 queued plots ahead of it
    for (int i = 0; i < 3; i++) begin
      x = int'($urandom_range(0, 159));
      y = int'($urandom_range(0, 119));
      c = int'($urandom_range(0, 7));
      set_plot(x, y, c, 1'b1);
      model_plot(x, y, c);
      tick();
    end
    set_plot(0, 0, 0, 1'b0);
    clear_start = 1'b1;
    clear_colour = 3'd2;
    tick();
    clear_start = 1'b0;
    clear_colour = 3'd5;
    check("clear_ready_falls", 64'(plot_ready), 64'd0);
    k = 0;
    done_seen = 1'b0;
    done_cyc = 0;
    ready_errs = 0;
    while (!done_seen && k < 25000) begin
      if (clear_done === 1'b1) begin
        done_seen = 1'b1;
        done_cyc = cyc;
      end else begin
        if (plot_ready !== 1'b0) ready_errs++;
        clear_start = (k == 5000);
        if (k >= 100 && k < 200)
          set_plot(int'($urandom_range(0, 159)), int'($urandom_range(0, 119)), 7, 1'b1);
        else
          set_plot(0, 0, 0, 1'b0);
        tick();
        k++;
      end
    end
    clear_start = 1'b0;
    check("clear_done_seen", 64'(done_seen), 64'd1);
    check("clear_ready_low", 64'(ready_errs), 64'd0);
    tick();
    check("clear_done_pulse", 64'(clear_done), 64'd0);
    check("clear_ready_rises", 64'(plot_ready), 64'd1);
    repeat (5) tick();
    check("clear_busy_after", 64'(busy), 64'd0);
    for (int a = 0; a < 19200; a++) begin
      exp_addr.push_back(a);
      exp_data.push_back(2);
    end
    if (got.size() > 0) check("clear_done_after_last", 64'(got[got.size()-1].cyc), 64'(done_cyc - 1));
    check_writes("clear");

    // reset in the middle of a clear
    clear_start = 1'b1;
    clear_colour = 3'd7;
    tick();
    clear_start = 1'b0;
    k = 0;
    while (!(fb_we === 1'b1 && fb_addr == 15'd1000) && k < 5000) begin
      tick();
      k++;
    end
    check("rst_mid_reached", 64'(fb_we === 1'b1 && fb_addr == 15'd1000), 64'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_we", 64'(fb_we), 64'd0);
    check("rst_mid_ready", 64'(plot_ready), 64'd1);
    check("rst_mid_clip", 64'(clip_count), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(clear_done), 64'd0);
    rst = 1'b0;
    got.delete();
    exp_addr.delete();
    exp_data.delete();
    repeat (5) tick();
    check("rst_mid_no_writes", 64'(got.size()), 64'd0);
    set_plot(1, 1, 4, 1'b1);
    model_plot(1, 1, 4);
    tick();
    set_plot(0, 0, 0, 1'b0);
    repeat (3) tick();
    check_writes("post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
